// File: rtl/design_09_pkg.sv
// Shared definitions for the design_09 requester: FSM encoding, stray-count
// width and the wait-counter width derivation.
package design_09_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } reqState_e;

  localparam int STRAY_W = 8;
  localparam logic [STRAY_W-1:0] STRAY_MAX = '1;

  // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  function automatic int timerWidth(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/design_09_req_timer.sv
// Wait counter for the requester: cleared on issue, counts WAIT cycles and
// flags the last permitted cycle.
module design_09_req_timer
  import design_09_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = timerWidth(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  assign expired = (count_q == LAST);

  // Hold at LAST so the counter cannot wrap if enable lingers.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/design_09_requester.sv
// Single-outstanding requester: accepts an operand pair, pulses start to the
// responder, waits for its result or a timeout, and holds the outcome.
module design_09_requester
  import design_09_pkg::*;
#(
  parameter int W       = 20,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  output logic               start,
  output logic [W-1:0]       a,
  output logic [W-1:0]       b,
  input  logic [W-1:0]       y,
  input  logic               valid,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_y,
  output logic               res_timeout,
  output logic [STRAY_W-1:0] stray_cnt
);

  reqState_e          state_q, state_d;
  logic [W-1:0]       opA_q, opA_d;
  logic [W-1:0]       opB_q, opB_d;
  logic [W-1:0]       resY_q, resY_d;
  logic               resTimeout_q, resTimeout_d;
  logic [STRAY_W-1:0] strayCnt_q, strayCnt_d;
  logic               timerClr, timerEn, timerExpired;

  assign timerClr = (state_q == ISSUE);
  assign timerEn  = (state_q == WAIT);

  design_09_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timerClr),
    .en      (timerEn),
    .expired (timerExpired)
  );

  // The responder re-samples a/b every cycle, so they come straight from the
  // operand registers, which only change on an IDLE handshake.
  assign a           = opA_q;
  assign b           = opB_q;
  assign res_y       = resY_q;
  assign res_timeout = resTimeout_q;
  assign stray_cnt   = strayCnt_q;

  always_comb begin
    state_d      = state_q;
    opA_d        = opA_q;
    opB_d        = opB_q;
    resY_d       = resY_q;
    resTimeout_d = resTimeout_q;
    strayCnt_d   = strayCnt_q;
    in_ready     = 1'b0;
    start        = 1'b0;
    res_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          opA_d   = in_a;
          opB_d   = in_b;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A strobe on the last permitted cycle still wins over the timeout.
        if (valid) begin
          resY_d       = y;
          resTimeout_d = 1'b0;
          state_d      = HOLD;
        end else if (timerExpired) begin
          resY_d       = '0;
          resTimeout_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (valid && (state_q != WAIT) && (strayCnt_q != STRAY_MAX)) begin
      strayCnt_d = strayCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opA_q        <= '0;
      opB_q        <= '0;
      resY_q       <= '0;
      resTimeout_q <= 1'b0;
      strayCnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      opA_q        <= opA_d;
      opB_q        <= opB_d;
      resY_q       <= resY_d;
      resTimeout_q <= resTimeout_d;
      strayCnt_q   <= strayCnt_d;
    end
  end

endmodule

// File: tb/tb_design_09_requester.sv
// Scoreboard bench for design_09_requester: a behavioural responder answers
// after a programmable delay, expected results queue up at request time.
module tb_design_09_requester;

  localparam int W       = 20;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         to;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         start;
  logic [W-1:0] a, b, y;
  logic         valid;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_y;
  logic         res_timeout;
  logic [7:0]   stray_cnt;

  int   checkCount = 0;
  int   errCount = 0;
  int   cyc = 0;
  int   hsCycle = 0;
  int   startCycle = -1;
  int   resCycle = -1;
  int   resCount = 0;
  exp_t expQ[$];
  exp_t monE;

  logic [W-1:0] expA = '0, expB = '0;
  logic         respValid = 1'b0, injValid = 1'b0;
  logic [W-1:0] respData = '0, injY = '0;
  int           respDelay = 0;
  int           cd = 0;
  bit           armed = 1'b0;
  logic         prevStart = 1'b0;
  logic         prevResValid = 1'b0;

  design_09_requester #(
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .start       (start),
    .a           (a),
    .b           (b),
    .y           (y),
    .valid       (valid),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y       (res_y),
    .res_timeout (res_timeout),
    .stray_cnt   (stray_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign valid = respValid | injValid;
  assign y     = respValid ? respData : injY;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Responder: answers respDelay cycles after seeing start (0 = never).
  always @(negedge clk) begin
    respValid = 1'b0;
    if (armed) begin
      if (cd == 1) begin
        respValid = 1'b1;
        armed     = 1'b0;
      end else begin
        cd--;
      end
    end
    if (start) begin
      checkOutput("start_pulse", {31'd0, prevStart}, 0);
      checkOutput("a_at_start", a, expA);
      checkOutput("b_at_start", b, expB);
      startCycle = cyc;
      if (respDelay > 0) begin
        armed = 1'b1;
        cd    = respDelay;
      end
    end
    prevStart = start;
  end

  // Result monitor: every new res_valid pops one scoreboard entry.
  always @(negedge clk) begin
    if (res_valid && !prevResValid) begin
      resCount++;
      resCycle = cyc;
      checkOutput("sb_pending", {31'd0, (expQ.size() != 0)}, 1);
      if (expQ.size() != 0) begin
        monE = expQ.pop_front();
        checkOutput("res_y", res_y, monE.y);
        checkOutput("res_timeout", {31'd0, res_timeout}, {31'd0, monE.to});
      end
      checkOutput("a_in_hold", a, expA);
      checkOutput("b_in_hold", b, expB);
    end
    prevResValid = res_valid;
  end

  task automatic applyStimulus(input logic [W-1:0] aVal, input logic [W-1:0] bVal,
                               input logic [W-1:0] yVal, input int delay,
                               input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      nextCycle();
      n++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 1);
    expA      = aVal;
    expB      = bVal;
    respData  = yVal;
    respDelay = delay;
    if (push) begin
      e.to = (delay == 0) || (delay > TIMEOUT);
      e.y  = e.to ? '0 : yVal;
      expQ.push_back(e);
    end
    in_valid = 1'b1;
    in_a     = aVal;
    in_b     = bVal;
    hsCycle  = cyc;
    nextCycle();
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input int maxCyc);
    int base, n;
    base = resCount;
    n    = 0;
    while (resCount == base && n < maxCyc) begin
      nextCycle();
      n++;
    end
    checkOutput("res_arrived", resCount - base, 1);
  endtask

  task automatic strayPulse(input logic [W-1:0] yVal);
    injY     = yVal;
    injValid = 1'b1;
    nextCycle();
    injValid = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 1);
    checkOutput({tag, "_start"}, {31'd0, start}, 0);
    checkOutput({tag, "_a"}, a, 0);
    checkOutput({tag, "_b"}, b, 0);
    checkOutput({tag, "_res_valid"}, {31'd0, res_valid}, 0);
    checkOutput({tag, "_res_y"}, res_y, 0);
    checkOutput({tag, "_res_timeout"}, {31'd0, res_timeout}, 0);
    checkOutput({tag, "_stray"}, stray_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [W-1:0] yv;
    int d;

    repeat (3) nextCycle();
    checkResetState("reset");

    // Handshake on the very first edge after release.
    rst_n = 1'b1;
    applyStimulus(20'h00005, 20'h00003, 20'h00008, 1, 1'b1);
    waitResult(10);
    checkOutput("start_lat", startCycle - hsCycle, 1);
    checkOutput("res_lat", resCycle - hsCycle, 3);
    nextCycle();

    $display("[TB] back-pressure");
    res_ready = 1'b0;
    applyStimulus(20'h00003, 20'h00004, 20'hFEDCB, 3, 1'b1);
    waitResult(20);
    repeat (5) begin
      nextCycle();
      checkOutput("bp_valid", {31'd0, res_valid}, 1);
      checkOutput("bp_y", res_y, 20'hFEDCB);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 0);
    end
    res_ready = 1'b1;
    nextCycle();
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 1);
    checkOutput("bp_release_valid", {31'd0, res_valid}, 0);

    $display("[TB] timeout and boundary");
    applyStimulus(20'h00001, 20'h00002, 20'h55555, 0, 1'b1);
    waitResult(TIMEOUT + 10);
    checkOutput("timeout_lat", resCycle - startCycle, TIMEOUT + 1);
    nextCycle();
    applyStimulus(20'h00006, 20'h00007, 20'h12345, TIMEOUT, 1'b1);
    waitResult(TIMEOUT + 10);
    checkOutput("boundary_lat", resCycle - startCycle, TIMEOUT + 1);
    nextCycle();

    $display("[TB] stray strobes");
    checkOutput("stray_none", stray_cnt, 0);
    strayPulse(20'h11111);
    nextCycle();
    strayPulse(20'h11111);
    checkOutput("stray_idle", stray_cnt, 2);
    res_ready = 1'b0;
    applyStimulus(20'h00007, 20'h00008, 20'h00777, 1, 1'b1);
    waitResult(10);
    strayPulse(20'h22222);
    checkOutput("stray_hold", stray_cnt, 3);
    checkOutput("stray_hold_y", res_y, 20'h00777);
    checkOutput("stray_hold_valid", {31'd0, res_valid}, 1);
    res_ready = 1'b1;
    nextCycle();
    injY     = 20'h33333;
    injValid = 1'b1;
    repeat (300) nextCycle();
    injValid = 1'b0;
    checkOutput("stray_sat", stray_cnt, 255);

    $display("[TB] reset mid-WAIT");
    rst_n = 1'b0;
    #1;
    checkOutput("rst_clear_stray", stray_cnt, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(20'h00009, 20'h0000A, 20'h0, 0, 1'b0);
    repeat (4) nextCycle();
    rst_n = 1'b0;
    #1;
    checkResetState("midwait");
    nextCycle();
    rst_n = 1'b1;
    base = resCount;
    strayPulse(20'h0ABCD);
    repeat (TIMEOUT + 4) nextCycle();
    checkOutput("rst_no_result", resCount - base, 0);
    checkOutput("rst_stray", stray_cnt, 1);
    applyStimulus(20'h0000A, 20'h0000B, 20'h00015, 2, 1'b1);
    waitResult(10);
    nextCycle();

    $display("[TB] randomised requests");
    for (int i = 0; i < 4; i++) begin
      d  = $urandom_range(1, TIMEOUT);
      yv = W'($urandom);
      applyStimulus(W'($urandom), W'($urandom), yv, d, 1'b1);
      waitResult(TIMEOUT + 10);
      nextCycle();
    end

    checkOutput("sb_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errCount);
    $finish;
  end

endmodule
